// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering the multicycle
// datapath's held read/write request with a one-cycle mem_resp pulse.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   mem_read         : read request, held until mem_resp is sampled
//   mem_write        : write request, held until mem_resp is sampled
//   mem_address      : byte address, word index = [ADDR_BITS+1:2]
//   mem_byte_enable  : write lane enables (ignored on reads)
//   mem_wdata        : write data
//   mem_rdata        : registered read data, held until next read
//   mem_resp         : one-cycle completion pulse
//   proto_err        : sticky initiator protocol-violation flag
module mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  localparam int WORDS = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 op_wr;
  logic [31:0]          addr_q;
  logic [3:0]           be_q;
  logic [31:0]          wdata_q;
  logic [ADDR_BITS-1:0] idx_q;

  logic [31:0] mem [WORDS];

  logic                 accept;
  logic                 both;
  logic                 viol;
  logic                 go_resp;
  logic                 rd_en;
  logic                 we;
  logic [ADDR_BITS-1:0] rd_idx;

  assign idx_q = addr_q[ADDR_BITS+1:2];

  // The full byte address is latched so any change while busy is
  // flagged, even in bits that alias to the same word.
  always_comb begin
    accept  = mem_read ^ mem_write;
    both    = mem_read & mem_write;
    viol    = (op_wr ? !mem_write : !mem_read)
            | (op_wr ? mem_read : mem_write)
            | (mem_address != addr_q);
    go_resp = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    unique case (state)
      IDLE: begin
        rd_idx  = mem_address[ADDR_BITS+1:2];
        go_resp = accept && (LATENCY == 1);
        rd_en   = go_resp && mem_read;
      end
      WAIT: begin
        go_resp = (cnt == 4'd1);
        rd_en   = go_resp && !op_wr;
      end
      default: begin
      end
    endcase
    // Reset discards a write that would retire on the same edge.
    we = (state == RESP) && op_wr && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      mem_resp  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      mem_resp <= go_resp;
      unique case (state)
        IDLE: begin
          if (both) proto_err <= 1'b1;
          if (accept) begin
            op_wr   <= mem_write;
            addr_q  <= mem_address;
            be_q    <= mem_byte_enable;
            wdata_q <= mem_wdata;
            cnt     <= CNT_INIT;
            state   <= go_resp ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (viol) proto_err <= 1'b1;
          cnt <= cnt - 4'd1;
          if (go_resp) state <= RESP;
        end
        RESP: begin
          if (viol) proto_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array with byte-lane writes and one registered read port.
  // Writes retire in RESP, reads load when entering RESP, so they
  // never share an edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
    if (rst) begin
      mem_rdata <= '0;
    end else if (rd_en) begin
      mem_rdata <= mem[rd_idx];
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Synthesizable single-port word memory that answers the multicycle datapath's memory interface.
- The control FSM holds mem_read/mem_write until it samples mem_resp; this block is the other end.
- It latches each request, waits a configurable latency, pulses mem_resp for exactly one cycle, returns read data and performs byte-enabled writes.
- Used as instruction/data memory in the integration bench and in FPGA bring-up.

Parameters:
ADDR_BITS, 10, word-index width; capacity 2^ADDR_BITS 32-bit words (default 4 KiB)
LATENCY, 2, cycles from request acceptance to mem_resp; legal range 1..15

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
mem_read  input  1  read request, held high by initiator until mem_resp sampled
mem_write  input  1  write request, held high by initiator until mem_resp sampled
mem_address  input  32  byte address; word index = mem_address[ADDR_BITS+1:2]
mem_byte_enable  input  4  write lane enables, bit i selects wdata[8i+7:8i]; ignored on reads
mem_wdata  input  32  write data
mem_rdata  output  32  read data, registered, valid in the mem_resp cycle and held until next read completes
mem_resp  output  1  one-cycle completion pulse
proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst high at a clock edge): state IDLE; mem_resp=0, mem_rdata=0, proto_err=0, latency counter=0; a pending transaction is discarded (no array write). Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE: exactly one of mem_read/mem_write high means accept. Latch op, word index, byte_enable and wdata; load counter=LATENCY-1; go to WAIT, or directly to RESP if LATENCY=1.
- IDLE with both mem_read and mem_write high: no accept, set proto_err, stay IDLE.
- WAIT: decrement counter each cycle; at counter==1 go to RESP. mem_resp is high in cycle A+LATENCY, where A is the accept cycle.
- RESP: mem_resp=1 for this cycle only; always return to IDLE next.
- Reads: mem_rdata is registered so it shows array[latched index] in the RESP cycle. The word read is the contents after any completed earlier write.
- Writes: array lanes with latched byte_enable=1 are updated on the edge ending the RESP cycle; other lanes are unchanged. mem_rdata is unchanged by writes. byte_enable=0000 gives a normal handshake with no array change.
- Request still high in the cycle after RESP (IDLE): treated as a new transaction.
- Initiator violations while in WAIT or RESP set proto_err:
  - request dropped;
  - op changed;
  - mem_address changed;
  - both read and write high.
  In every case the transaction still completes using the latched values.
- Address wrap: mem_address[1:0] and bits above ADDR_BITS+1 are ignored, so addresses alias modulo 2^(ADDR_BITS+2).
- proto_err stays high until rst.
- Array: inferred synchronous RAM, 4 byte-lane write enables, one read port.

Test Plan:
1. LATENCY=2. Write 0xDEADBEEF to 0x40 (be=1111), then read 0x40. Required:
   - each mem_resp is high exactly one cycle, 2 cycles after accept;
   - mem_rdata=0xDEADBEEF in the read's resp cycle.
2. Byte enables. Write 0x11223344 be=1111, then write 0xAABBCCDD be=0101 to the same address, then read. Required: 0x11BB33DD.
3. LATENCY=1 and LATENCY=5 builds. Hold mem_read high. Required: mem_resp at accept+1 and accept+5 respectively; mem_read left high one extra cycle starts a second transaction.
4. Assert mem_read and mem_write together in IDLE. Required: no mem_resp, proto_err=1 and held; read-address change in WAIT still completes with the original address data.
5. rst during WAIT of a write of 0x5555AAAA to 0x80 (old content 0x0). Required:
   - mem_resp never pulses, mem_rdata=0, proto_err=0;
   - a subsequent read of 0x80 returns 0x0.
6. Aliasing, ADDR_BITS=10. Write 0x12345678 to 0x0000_1004, then read 0x0000_0004 and 0x0000_0006. Required: both return 0x12345678.
